// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehaze atmospheric-light path.
// Holds the frame FSM state enum, accumulator format and frame-size helper.
package dehaze_pkg;

    localparam int ACC_W  = 16;
    localparam int FRAC_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        LATCH,
        FILTER,
        PUBLISH
    } light_state_t;

    function automatic int unsigned pix_total(
        input logic [9:0] hdisp,
        input logic [9:0] vdisp
    );
        return int'(hdisp) * int'(vdisp);
    endfunction

    localparam int unsigned PIX_TOTAL = pix_total(10'd800, 10'd600);

endpackage

// File: rtl/atmos_iir_filter.sv
// Temporal IIR smoother for the airlight estimate, Q8.8 accumulator.
// Ports: clk, rst_n, seed/update strobes, cur, shift, a_min, a_max -> acc, result.
module atmos_iir_filter
    import dehaze_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed,
    input  logic             update,
    input  logic [7:0]       cur,
    input  logic [2:0]       shift,
    input  logic [7:0]       a_min,
    input  logic [7:0]       a_max,
    output logic [ACC_W-1:0] acc,
    output logic [7:0]       result
);

    logic signed [ACC_W:0] diff;
    logic signed [ACC_W:0] step;
    logic signed [ACC_W:0] sum;
    logic [8:0]            rnd;
    logic [7:0]            sat;

    always_comb begin
        diff = signed'({1'b0, cur, {FRAC_W{1'b0}}}) - signed'({1'b0, acc});
        step = diff >>> shift;
        // The step never overshoots the target, so the sum stays in range.
        sum  = signed'({1'b0, acc}) + step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (seed) begin
            acc <= {cur, {FRAC_W{1'b0}}};
        end else if (update) begin
            acc <= sum[ACC_W-1:0];
        end
    end

    always_comb begin
        // Round half up on the fraction MSB, saturate, then clamp.
        rnd = {1'b0, acc[ACC_W-1:FRAC_W]} + 9'(acc[FRAC_W-1]);
        sat = rnd[8] ? 8'hFF : rnd[7:0];
        if (sat < a_min) begin
            result = a_min;
        end else if (sat > a_max) begin
            result = a_max;
        end else begin
            result = sat;
        end
    end

endmodule

// File: rtl/atmos_light_ctrl.sv
// Frame-level controller: checks pixel count, latches, smooths and publishes airlight.
// Ports: vsync/clken/est_* in, cfg_* in, a_valid/a_ack handshake, frame_err/a_drop pulses, frame_cnt.
module atmos_light_ctrl
    import dehaze_pkg::*;
#(
    parameter logic [9:0] IMG_HDISP = 10'd800,
    parameter logic [9:0] IMG_VDISP = 10'd600,
    parameter int         PIX_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_clken,
    input  logic [7:0]  est_light,
    input  logic [9:0]  est_pos_x,
    input  logic [9:0]  est_pos_y,
    input  logic        cfg_enable,
    input  logic        cfg_freeze,
    input  logic [2:0]  cfg_shift,
    input  logic [7:0]  cfg_a_min,
    input  logic [7:0]  cfg_a_max,
    output logic        a_valid,
    input  logic        a_ack,
    output logic [7:0]  a_value,
    output logic [9:0]  a_pos_x,
    output logic [9:0]  a_pos_y,
    output logic        frame_err,
    output logic        a_drop,
    output logic [15:0] frame_cnt
);

    localparam logic [PIX_W-1:0] FRAME_PIX =
        PIX_W'(pix_total(IMG_HDISP, IMG_VDISP));

    light_state_t     state;
    light_state_t     state_nxt;
    logic             vsync_r;
    logic             rise;
    logic             fall;
    logic [PIX_W-1:0] pix_cnt;
    logic             pix_bad;
    logic             seeded;
    logic [7:0]       lat_light;
    logic [9:0]       lat_x;
    logic [9:0]       lat_y;
    logic             filt_en;
    logic             pub_en;
    logic [ACC_W-1:0] acc;
    logic [7:0]       result;

    assign rise    = per_frame_vsync & ~vsync_r;
    assign fall    = ~per_frame_vsync & vsync_r;
    assign pix_bad = (pix_cnt != FRAME_PIX);
    assign filt_en = (state == FILTER);
    assign pub_en  = (state == PUBLISH);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (fall && cfg_enable) state_nxt = ACTIVE;
            ACTIVE:  if (rise) state_nxt = LATCH;
            LATCH:   state_nxt = (pix_bad || cfg_freeze) ? IDLE : FILTER;
            FILTER:  state_nxt = PUBLISH;
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!cfg_enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vsync_r <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_r <= per_frame_vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
        end else if (state == IDLE) begin
            pix_cnt <= '0;
        end else if (state == ACTIVE && per_frame_clken &&
                     !per_frame_vsync && !(&pix_cnt)) begin
            pix_cnt <= pix_cnt + PIX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_light <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
        end else if (state == LATCH) begin
            lat_light <= est_light;
            lat_x     <= est_pos_x;
            lat_y     <= est_pos_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded <= 1'b0;
        end else if (!cfg_enable) begin
            seeded <= 1'b0;
        end else if (filt_en) begin
            seeded <= 1'b1;
        end
    end

    atmos_iir_filter u_iir (
        .clk    (clk),
        .rst_n  (rst_n),
        .seed   (filt_en & ~seeded),
        .update (filt_en & seeded),
        .cur    (lat_light),
        .shift  (cfg_shift),
        .a_min  (cfg_a_min),
        .a_max  (cfg_a_max),
        .acc    (acc),
        .result (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid   <= 1'b0;
            a_value   <= '0;
            a_pos_x   <= '0;
            a_pos_y   <= '0;
            frame_err <= 1'b0;
            a_drop    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            frame_err <= (state == LATCH) && pix_bad;
            // An ack alongside PUBLISH retires the old value, so no drop.
            a_drop    <= pub_en && a_valid && !a_ack;
            if (pub_en) begin
                a_valid   <= 1'b1;
                a_value   <= result;
                a_pos_x   <= lat_x;
                a_pos_y   <= lat_y;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (a_valid && a_ack) begin
                a_valid   <= 1'b0;
            end
        end
    end

endmodule
